// File: rtl/fns_dec_seq.sv
// fns_dec_seq: multi-cycle Fibonacci-numeral-system decoder, BPC bits/cycle.
// Optional FNS_CHECK_EN adds err output flagging adjacent 1 bits.
module fns_dec_seq #(
  parameter int CODE_W = 16,
  parameter int BPC    = 4,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              busy
`ifdef FNS_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int NG = CODE_W / BPC;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, nxt;

  logic [CODE_W-1:0] sr;
  logic [DATA_W-1:0] acc, wa, wb;
  logic [DATA_W-1:0] sum, na, nb;
  logic [DATA_W-1:0] ga, gb, gt;
  logic [CW-1:0]     cnt;
  logic              last;

  assign last = (cnt == CW'(NG - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Weighted sum of one BPC group; weights roll forward as a Fibonacci pair
  always_comb begin
    ga  = wa;
    gb  = wb;
    gt  = '0;
    sum = acc;
    for (int j = 0; j < BPC; j++) begin
      if (sr[j]) sum = sum + ga;
      gt = ga + gb;
      ga = gb;
      gb = gt;
    end
    na = ga;
    nb = gb;
  end

`ifdef FNS_CHECK_EN
  logic errp;
`endif

  // Datapath: capture, per-group accumulate, result load
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      acc     <= '0;
      wa      <= '0;
      wb      <= '0;
      cnt     <= '0;
      dataout <= '0;
`ifdef FNS_CHECK_EN
      errp    <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr  <= codein;
            acc <= '0;
            wa  <= DATA_W'(1);
            wb  <= DATA_W'(1);
            cnt <= '0;
`ifdef FNS_CHECK_EN
            errp <= |(codein[CODE_W-1:1] & codein[CODE_W-2:0]);
`endif
          end
        end
        RUN: begin
          acc <= sum;
          wa  <= na;
          wb  <= nb;
          sr  <= sr >> BPC;
          cnt <= cnt + 1'b1;
          if (last) begin
            dataout <= sum;
`ifdef FNS_CHECK_EN
            err     <= errp;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fns_dec_seq.sv
// tb_fns_dec_seq: directed and random checks of fns_dec_seq
// at BPC=4 plus BPC=1/2/16 latency variants.
module tb_fns_dec_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        vsel = 1'b0;
  logic [15:0] codein = '0;

  logic        in_ready, out_valid, busy;
  logic [11:0] dataout;
  logic        mv, vv;
  logic        ir_v [3];
  logic        ov_v [3];
  logic        bz_v [3];
  logic [11:0] do_v [3];
`ifdef FNS_CHECK_EN
  logic        err;
  logic        er_v [3];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mv = in_valid & ~vsel;
  assign vv = in_valid & vsel;

  fns_dec_seq u4 (
    .clk(clk), .rst(rst), .in_valid(mv), .in_ready(in_ready),
    .codein(codein), .out_valid(out_valid), .out_ready(out_ready),
    .dataout(dataout), .busy(busy)
`ifdef FNS_CHECK_EN
    , .err(err)
`endif
  );

  fns_dec_seq #(.BPC(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(vv), .in_ready(ir_v[0]),
    .codein(codein), .out_valid(ov_v[0]), .out_ready(out_ready),
    .dataout(do_v[0]), .busy(bz_v[0])
`ifdef FNS_CHECK_EN
    , .err(er_v[0])
`endif
  );

  fns_dec_seq #(.BPC(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(vv), .in_ready(ir_v[1]),
    .codein(codein), .out_valid(ov_v[1]), .out_ready(out_ready),
    .dataout(do_v[1]), .busy(bz_v[1])
`ifdef FNS_CHECK_EN
    , .err(er_v[1])
`endif
  );

  fns_dec_seq #(.BPC(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(vv), .in_ready(ir_v[2]),
    .codein(codein), .out_valid(ov_v[2]), .out_ready(out_ready),
    .dataout(do_v[2]), .busy(bz_v[2])
`ifdef FNS_CHECK_EN
    , .err(er_v[2])
`endif
  );

  function automatic int ref_dec(input logic [15:0] c);
    int a, b, t, s;
    a = 1; b = 1; s = 0;
    for (int k = 0; k < 16; k++) begin
      if (c[k]) s += a;
      t = a + b; a = b; b = t;
    end
    return s;
  endfunction

  function automatic logic [15:0] legal_code();
    logic [15:0] x;
    x = 16'($urandom);
    return x & ~(x << 1);
  endfunction

  task automatic run_one(input logic [15:0] c,
                         output int lat, output logic [11:0] val);
    @(negedge clk);
    codein = c;
    in_valid = 1'b1;
    lat = 0;
    repeat (40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
    end
    if (!out_valid) lat = 99;
    val = dataout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    checks++;
    if (dataout !== 12'd0) begin
      errors++; $display("FAIL rst_dataout: got %0d want 0", dataout);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [11:0] v;
    out_ready = 1'b1;
    run_one(16'h0001, lat, v);
    checks++;
    if (lat != 5) begin
      errors++; $display("FAIL basic_latency: got %0d want 5", lat);
    end
    checks++;
    if (v !== 12'd1) begin
      errors++; $display("FAIL basic_value: got %0d want 1", v);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_done: got %b want 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_xfer: got ready=%b valid=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] cs [4];
    int          ex [4];
    int          lat;
    logic [11:0] v;
    cs = '{16'h8000, 16'hFFFF, 16'h5555, 16'hAAAA};
    ex = '{987, 2583, 987, 1596};
    for (int i = 0; i < 4; i++) begin
      run_one(cs[i], lat, v);
      checks++;
      if (v !== 12'(ex[i])) begin
        errors++;
        $display("FAIL pat_%h: got %0d want %0d", cs[i], v, ex[i]);
      end
      checks++;
      if (lat != 5) begin
        errors++;
        $display("FAIL pat_lat_%h: got %0d want 5", cs[i], lat);
      end
    end
  endtask

  task automatic test_variants();
    logic [15:0] cs [4];
    int          ex [4];
    int          wl [3];
    int          lat [3];
    logic [11:0] val [3];
    cs = '{16'h8000, 16'hFFFF, 16'h5555, 16'hAAAA};
    ex = '{987, 2583, 987, 1596};
    wl = '{17, 9, 2};
    out_ready = 1'b1;
    vsel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lat = '{0, 0, 0};
      val = '{12'd0, 12'd0, 12'd0};
      @(negedge clk);
      codein = cs[i];
      in_valid = 1'b1;
      for (int e = 1; e <= 25; e++) begin
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++)
          if (ov_v[k] && lat[k] == 0) begin
            lat[k] = e;
            val[k] = do_v[k];
          end
        if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lat[k] != wl[k]) begin
          errors++;
          $display("FAIL var%0d_lat_%h: got %0d want %0d",
                   k, cs[i], lat[k], wl[k]);
        end
        checks++;
        if (val[k] !== 12'(ex[i])) begin
          errors++;
          $display("FAIL var%0d_val_%h: got %0d want %0d",
                   k, cs[i], val[k], ex[i]);
        end
      end
    end
    @(negedge clk);
    vsel = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [11:0] hold;
    bit          ok;
    out_ready = 1'b0;
    @(negedge clk);
    codein = 16'h5555;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      codein = 16'hAAAA;
      if (out_valid) break;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_valid: got %b want 1", out_valid);
    end
    hold = dataout;
    checks++;
    if (hold !== 12'd987) begin
      errors++; $display("FAIL bp_value: got %0d want 987", hold);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      ok = (dataout === hold) && (in_ready === 1'b0) &&
           (out_valid === 1'b1);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_stall%0d: got d=%0d r=%b v=%b want %0d/0/1",
                 i, dataout, in_ready, out_valid, hold);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_single_xfer: got v=%b r=%b want 0/1",
               out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL bp_second_accept: got busy=%b want 1", busy);
    end
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || dataout !== 12'd1596) begin
      errors++;
      $display("FAIL bp_second_val: got v=%b d=%0d want 1/1596",
               out_valid, dataout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cs [2];
    int          ex [2];
    int          capt [2];
    logic [11:0] got [2];
    int          nc, nx;
    bit          cap, xf;
    cs = '{16'h0001, 16'h0100};
    ex = '{1, 34};
    capt = '{0, 0};
    got = '{12'd0, 12'd0};
    nc = 0; nx = 0;
    out_ready = 1'b1;
    for (int e = 1; e <= 40 && nx < 2; e++) begin
      @(negedge clk);
      in_valid = (nc < 2);
      codein = (nc < 2) ? cs[nc] : 16'h0;
      cap = in_valid && in_ready;
      xf = out_valid && out_ready;
      if (xf) begin
        got[nx] = dataout;
        nx++;
      end
      @(posedge clk);
      if (cap) begin
        capt[nc] = e;
        nc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (capt[1] - capt[0] != 6) begin
      errors++;
      $display("FAIL b2b_period: got %0d want 6", capt[1] - capt[0]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got[i] !== 12'(ex[i])) begin
        errors++;
        $display("FAIL b2b_val%0d: got %0d want %0d", i, got[i], ex[i]);
      end
    end
  endtask

  task automatic test_abort();
    int          lat;
    logic [11:0] v;
    bit          seen;
    out_ready = 1'b1;
    @(negedge clk);
    codein = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        dataout !== 12'd0) begin
      errors++;
      $display("FAIL abort_reset: got r=%b v=%b b=%b d=%0d want 1/0/0/0",
               in_ready, out_valid, busy, dataout);
    end
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_no_output: got out_valid=1 want 0");
    end
    run_one(16'h0004, lat, v);
    checks++;
    if (v !== 12'd2 || lat != 5) begin
      errors++;
      $display("FAIL abort_next: got d=%0d lat=%0d want 2/5", v, lat);
    end
  endtask

`ifdef FNS_CHECK_EN
  task automatic test_err();
    logic [15:0] cs [3];
    int          ex [3];
    logic        ee [3];
    int          lat;
    logic [11:0] v;
    cs = '{16'h0003, 16'h0018, 16'h5555};
    ex = '{2, 8, 987};
    ee = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_one(cs[i], lat, v);
      checks++;
      if (v !== 12'(ex[i]) || err !== ee[i]) begin
        errors++;
        $display("FAIL err_%h: got d=%0d e=%b want %0d/%b",
                 cs[i], v, err, ex[i], ee[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] q [$];
    logic [15:0] cur, c;
    logic [11:0] dv;
    int          n, exv;
    bit          cap, xf;
    cur = legal_code();
    n = 0;
    for (int cyc = 0; cyc < 800 && n < 20; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      codein = cur;
      out_ready = 1'($urandom_range(0, 1));
      cap = in_ready;
      xf = out_valid && out_ready;
      dv = dataout;
      if (xf) begin
        c = q.pop_front();
        exv = ref_dec(c);
        checks++;
        if (dv !== 12'(exv)) begin
          errors++;
          $display("FAIL rand_%h: got %0d want %0d", c, dv, exv);
        end
        n++;
      end
      @(posedge clk);
      if (cap) begin
        q.push_back(cur);
        cur = legal_code();
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (n != 20) begin
      errors++; $display("FAIL rand_count: got %0d want 20", n);
    end
    for (int i = 0; i < 20; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_variants();
    test_backpressure();
    test_back_to_back();
    test_abort();
`ifdef FNS_CHECK_EN
    test_err();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
